// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the MEM/WB stage.
// Rev 1.0 - writeback select and load funct3 encodings.
`default_nettype none

package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// load_align: selects the addressed byte/halfword/word of a load and extends it.
// Rev 1.0 - combinational, raw (unqualified) misalign flag.
`default_nettype none

module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] raw_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o
);

  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_word = raw_i[31:0];
  assign w_byte = w_word[{addr_i, 3'b000} +: 8];
  assign w_half = w_word[{addr_i[1], 4'b0000} +: 16];

  // Unlisted funct3 values fall through to the word path for data and alignment.
  always_comb begin
    data_o     = XLEN'($signed(w_word));
    misalign_o = |addr_i;
    case (funct3_i)
      F3_LB: begin
        data_o     = XLEN'($signed(w_byte));
        misalign_o = 1'b0;
      end
      F3_LBU: begin
        data_o     = XLEN'(w_byte);
        misalign_o = 1'b0;
      end
      F3_LH: begin
        data_o     = XLEN'($signed(w_half));
        misalign_o = addr_i[0];
      end
      F3_LHU: begin
        data_o     = XLEN'(w_half);
        misalign_o = addr_i[0];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with stall/flush, load alignment,
// writeback select, x0/misalign write suppression and a retire counter. Rev 1.0.
`default_nettype none

module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              RegWrite_in,
  input  logic [1:0]        wb_sel_in,
  input  logic [2:0]        load_f3_in,
  input  logic [XLEN-1:0]   read_data_in,
  input  logic [XLEN-1:0]   alu_result_in,
  input  logic [XLEN-1:0]   pc_plus4_in,
  input  logic [REG_AW-1:0] rd_in,
  output logic              valid,
  output logic              RegWrite,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] rd,
  output logic              misalign,
  output logic [CNT_W-1:0]  retire_count
);

  logic              valid_q, valid_d;
  logic              regwrite_q, regwrite_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [XLEN-1:0]   load_data;
  logic              load_misalign;

  load_align #(.XLEN(XLEN)) u_load_align (
    .raw_i      (read_data_in),
    .addr_i     (alu_result_in[1:0]),
    .funct3_i   (load_f3_in),
    .data_o     (load_data),
    .misalign_o (load_misalign)
  );

  always_comb begin
    case (wb_sel_in)
      WB_MEM:  wb_data_d = load_data;
      WB_PC:   wb_data_d = pc_plus4_in;
      default: wb_data_d = alu_result_in;
    endcase
    valid_d    = valid_in;
    rd_d       = rd_in;
    misalign_d = valid_in & (wb_sel_in == WB_MEM) & load_misalign;
    regwrite_d = RegWrite_in & valid_in & ~misalign_d & (rd_in != '0);
    count_d    = valid_in ? count_q + CNT_W'(1) : count_q;
  end

  // Flush only kills the control bits; data/rd are don't-care behind valid=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wb_data_q  <= '0;
      rd_q       <= '0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      wb_data_q  <= wb_data_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign valid        = valid_q;
  assign RegWrite     = regwrite_q;
  assign wb_data      = wb_data_q;
  assign rd           = rd_q;
  assign misalign     = misalign_q;
  assign retire_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors against a behavioural MEM/WB model.
// Rev 1.0
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_in, RegWrite_in;
  logic [1:0]  wb_sel_in;
  logic [2:0]  load_f3_in;
  logic [31:0] read_data_in, alu_result_in, pc_plus4_in;
  logic [4:0]  rd_in;
  logic        valid, RegWrite, misalign;
  logic [31:0] wb_data;
  logic [4:0]  rd;
  logic [3:0]  retire_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  bit          m_valid, m_rw, m_mis;
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  int          m_cnt;

  mem_wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .valid_in     (valid_in),
    .RegWrite_in  (RegWrite_in),
    .wb_sel_in    (wb_sel_in),
    .load_f3_in   (load_f3_in),
    .read_data_in (read_data_in),
    .alu_result_in(alu_result_in),
    .pc_plus4_in  (pc_plus4_in),
    .rd_in        (rd_in),
    .valid        (valid),
    .RegWrite     (RegWrite),
    .wb_data      (wb_data),
    .rd           (rd),
    .misalign     (misalign),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] raw, input logic [1:0] a,
                                         input logic [2:0] f3);
    logic [31:0] t;
    case (f3)
      3'd0: begin t = (raw >> (8 * a)) & 32'hFF;      return t[7]  ? (t | 32'hFFFF_FF00) : t; end
      3'd4: return (raw >> (8 * a)) & 32'hFF;
      3'd1: begin t = (raw >> (16 * a[1])) & 32'hFFFF; return t[15] ? (t | 32'hFFFF_0000) : t; end
      3'd5: return (raw >> (16 * a[1])) & 32'hFFFF;
      default: return raw;
    endcase
  endfunction

  function automatic bit m_misfn(input logic [1:0] a, input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return a[0];
    return a != 2'd0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mis = 0; m_data = '0; m_rd = '0; m_cnt = 0;
  endtask

  task automatic model_update();
    bit mis;
    if (flush) begin
      m_valid = 0; m_rw = 0; m_mis = 0;
    end else if (!stall) begin
      mis     = valid_in && wb_sel_in == 2'd1 && m_misfn(alu_result_in[1:0], load_f3_in);
      m_valid = valid_in;
      m_rw    = RegWrite_in && valid_in && !mis && rd_in != 5'd0;
      m_data  = (wb_sel_in == 2'd1) ? m_load(read_data_in, alu_result_in[1:0], load_f3_in) :
                (wb_sel_in == 2'd2) ? pc_plus4_in : alu_result_in;
      m_rd    = rd_in;
      m_mis   = mis;
      if (valid_in) m_cnt = (m_cnt + 1) % 16;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",    64'(valid),        64'(m_valid));
      chk("RegWrite", 64'(RegWrite),     64'(m_rw));
      chk("wb_data",  64'(wb_data),      64'(m_data));
      chk("rd",       64'(rd),           64'(m_rd));
      chk("misalign", 64'(misalign),     64'(m_mis));
      chk("count",    64'(retire_count), 64'(m_cnt));
    end
  end

  // One clock: capture at posedge, outputs compared at negedge, return just after.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] rdat, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [4:0] d, input bit st, input bit fl);
    valid_in = v; RegWrite_in = rw; wb_sel_in = sel; load_f3_in = f3;
    read_data_in = rdat; alu_result_in = alu; pc_plus4_in = pc; rd_in = d;
    stall = st; flush = fl;
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_rw"},    64'(RegWrite), 64'd0);
    chk({tag, "_data"},  64'(wb_data), 64'd0);
    chk({tag, "_rd"},    64'(rd), 64'd0);
    chk({tag, "_mis"},   64'(misalign), 64'd0);
    chk({tag, "_cnt"},   64'(retire_count), 64'd0);
  endtask

  localparam logic [31:0] RAW = 32'h80F1_7F22;

  initial begin
    reset = 1'b1; stall = 0; flush = 0; valid_in = 0; RegWrite_in = 0;
    wb_sel_in = 0; load_f3_in = 0; read_data_in = 0; alu_result_in = 0;
    pc_plus4_in = 0; rd_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_zero("por");
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // some traffic, then an asynchronous reset in the middle of a cycle
    drive(1, 1, 2'b00, 3'd0, 0, 32'h55, 0, 5'd3, 0, 0);
    chk("alu_data", 64'(wb_data), 64'h55);
    drive(1, 1, 2'b00, 3'd0, 0, 32'h66, 0, 5'd4, 1, 0);
    #1 reset = 1'b1;
    model_reset();
    #1 chk_zero("midrst");
    reset = 1'b0;

    // x0 write suppression
    drive(1, 1, 2'b00, 3'd0, 0, 32'h1234, 0, 5'd0, 0, 0);
    chk("x0_valid", 64'(valid), 64'd1);
    chk("x0_rw",    64'(RegWrite), 64'd0);
    chk("x0_data",  64'(wb_data), 64'h0000_1234);
    chk("x0_cnt",   64'(retire_count), 64'd1);

    // load alignment
    drive(1, 1, 2'b01, 3'd0, RAW, 32'h3, 0, 5'd7, 0, 0);
    chk("lb3",  64'(wb_data), 64'hFFFF_FF80);
    drive(1, 1, 2'b01, 3'd4, RAW, 32'h1, 0, 5'd7, 0, 0);
    chk("lbu1", 64'(wb_data), 64'h0000_007F);
    drive(1, 1, 2'b01, 3'd1, RAW, 32'h2, 0, 5'd7, 0, 0);
    chk("lh2",  64'(wb_data), 64'hFFFF_80F1);
    drive(1, 1, 2'b01, 3'd5, RAW, 32'h0, 0, 5'd7, 0, 0);
    chk("lhu0", 64'(wb_data), 64'h0000_7F22);
    drive(1, 1, 2'b01, 3'd2, RAW, 32'h0, 0, 5'd7, 0, 0);
    chk("lw0",  64'(wb_data), 64'h80F1_7F22);
    chk("lw0_rw", 64'(RegWrite), 64'd1);

    // misaligned loads
    drive(1, 1, 2'b01, 3'd2, RAW, 32'h1002, 0, 5'd8, 0, 0);
    chk("lw_mis", 64'(misalign), 64'd1);
    chk("lw_mis_rw", 64'(RegWrite), 64'd0);
    chk("lw_mis_cnt", 64'(retire_count), 64'd7);
    drive(1, 1, 2'b01, 3'd1, RAW, 32'h1001, 0, 5'd8, 0, 0);
    chk("lh_mis", 64'(misalign), 64'd1);
    drive(1, 1, 2'b01, 3'd7, RAW, 32'h1001, 0, 5'd8, 0, 0);   // reserved funct3 -> word rules

    // stall holds, then stall+flush makes a bubble
    drive(1, 1, 2'b00, 3'd0, 0, 32'hAA, 0, 5'd5, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(1, 1, 2'b00, 3'd0, 0, 32'h100 + 32'(i), 0, 5'd9 + 5'(i), 1, 0);
    chk("stall_rd",   64'(rd), 64'd5);
    chk("stall_data", 64'(wb_data), 64'hAA);
    drive(1, 1, 2'b00, 3'd0, 0, 32'hBB, 0, 5'd6, 1, 1);
    chk("flush_valid", 64'(valid), 64'd0);
    chk("flush_rw",    64'(RegWrite), 64'd0);
    chk("flush_cnt",   64'(retire_count), 64'd10);

    // PC+4 select and reserved wb_sel
    drive(1, 1, 2'b10, 3'd0, 0, 32'hDEAD, 32'h108, 5'd1, 0, 0);
    chk("pc4_data", 64'(wb_data), 64'h108);
    chk("pc4_rw",   64'(RegWrite), 64'd1);
    drive(1, 1, 2'b11, 3'd0, RAW, 32'h77, 32'h200, 5'd2, 0, 0);
    chk("sel11_data", 64'(wb_data), 64'h77);

    // invalid entry does not count; then count up to wrap
    drive(0, 1, 2'b00, 3'd0, 0, 32'h1, 0, 5'd3, 0, 0);
    chk("inv_rw", 64'(RegWrite), 64'd0);
    for (int i = 0; i < 3; i++)
      drive(1, 1, 2'b00, 3'd0, 0, 32'(i), 0, 5'd3, 0, 0);
    chk("cnt15", 64'(retire_count), 64'd15);
    drive(1, 1, 2'b00, 3'd0, 0, 32'h9, 0, 5'd3, 0, 0);
    chk("cnt_wrap", 64'(retire_count), 64'd0);

    drive(0, 0, 2'b00, 3'd0, 0, 0, 0, 5'd0, 0, 0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
